// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_iterative_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_opr1;
  logic [WIDTH-1:0] i_opr2;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic             o_div_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_opr1, i_opr2, i_flush,
    input  o_busy, o_done, o_div_zero, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_opr1, i_opr2, i_flush,
    output o_busy, o_done, o_div_zero, o_hi, o_lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per cycle,
// followed by a single sign-fix / accumulate / write-back cycle.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input logic           i_clk,
  input logic           i_rst,
  mdu_iterative_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMadd  = 3'd4;
  localparam logic [2:0] OpMaddu = 3'd5;
  localparam logic [2:0] OpMthi  = 3'd6;
  localparam logic [2:0] OpMtlo  = 3'd7;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // {upper, multiplier} or {remainder, quotient}
  logic                 neg_q, neg_d;       // negate product / quotient at write-back
  logic                 rem_neg_q, rem_neg_d;
  logic                 dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0]     raw1_q, raw1_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 in_signed, in_is_div, in_neg1, in_neg2;
  logic [WIDTH-1:0]     in_abs1, in_abs2;
  logic                 cur_is_div;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quot, rem;

  // Operand conditioning and single-step datapaths.
  always_comb begin
    in_signed  = (bus.i_op == OpMult) || (bus.i_op == OpDiv) || (bus.i_op == OpMadd);
    in_is_div  = (bus.i_op == OpDiv) || (bus.i_op == OpDivu);
    in_neg1    = in_signed && bus.i_opr1[WIDTH-1];
    in_neg2    = in_signed && bus.i_opr2[WIDTH-1];
    in_abs1    = in_neg1 ? -bus.i_opr1 : bus.i_opr1;
    in_abs2    = in_neg2 ? -bus.i_opr2 : bus.i_opr2;
    cur_is_div = (op_q == OpDiv) || (op_q == OpDivu);

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Borrow out of the (WIDTH+1)-bit subtract means the divisor did not fit.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, mcand_q};
    q_bit    = ~div_diff[WIDTH];
    div_next = {(q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};

    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register updates; flush wins over everything except reset.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dz_pend_d  = dz_pend_q;
    raw1_d     = raw1_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      StIdle: begin
        if (bus.i_start && !bus.i_flush) begin
          if (bus.i_op == OpMthi) begin
            hi_d = bus.i_opr1;
          end else if (bus.i_op == OpMtlo) begin
            lo_d = bus.i_opr1;
          end else begin
            state_d   = StCalc;
            op_d      = bus.i_op;
            cnt_d     = '0;
            neg_d     = in_neg1 ^ in_neg2;
            rem_neg_d = in_neg1;
            dz_pend_d = (bus.i_opr2 == '0);
            raw1_d    = bus.i_opr1;
            if (in_is_div) begin
              mcand_d = in_abs2;
              acc_d   = {{WIDTH{1'b0}}, in_abs1};
            end else begin
              mcand_d = in_abs1;
              acc_d   = {{WIDTH{1'b0}}, in_abs2};
            end
          end
        end
      end
      StCalc: begin
        if (bus.i_flush) begin
          state_d = StIdle;
        end else begin
          acc_d = cur_is_div ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
        if (!bus.i_flush) begin
          done_d = 1'b1;
          case (op_q)
            OpMult, OpMultu: {hi_d, lo_d} = prod;
            OpMadd, OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod;
            OpDiv, OpDivu: begin
              div_zero_d = dz_pend_q;
              if (dz_pend_q) begin
                hi_d = raw1_q;
                lo_d = '1;
              end else begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath and architectural registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q       <= '0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      raw1_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_pend_q  <= dz_pend_d;
      raw1_q     <= raw1_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.o_busy     = (state_q != StIdle);
  assign bus.o_done     = done_q;
  assign bus.o_div_zero = div_zero_q;
  assign bus.o_hi       = hi_q;
  assign bus.o_lo       = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table plus scoreboard of expected write-backs.
module tb_mdu_iterative;

  localparam int unsigned W = 32;
  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMadd  = 3'd4;
  localparam logic [2:0] OpMaddu = 3'd5;
  localparam logic [2:0] OpMthi  = 3'd6;
  localparam logic [2:0] OpMtlo  = 3'd7;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   start_cyc;
  exp_t sb[$];
  vec_t vecs[12];
  logic [W-1:0] last_hi, last_lo;
  logic         last_dz;

  mdu_iterative_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare each write-back against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(bus.o_hi), 64'(e.hi));
        check("lo", 64'(bus.o_lo), 64'(e.lo));
        check("div_zero", 64'(bus.o_div_zero), 64'(e.dz));
      end
    end
  end

  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input exp_t e);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_opr1  = a;
    bus.i_opr2  = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    start_cyc = cyc;
    if (push) sb.push_back(e);
    check("busy_after_start", 64'(bus.o_busy), 64'd1);
  endtask

  task automatic wait_done();
    while (!bus.o_done && (cyc - start_cyc) < 100) begin
      @(posedge clk);
      #1;
    end
    check("latency", 64'(cyc - start_cyc), 64'(W + 1));
    check("busy_at_done", 64'(bus.o_busy), 64'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    launch(op, a, b, 1'b1, e);
    wait_done();
    last_hi = hi;
    last_lo = lo;
    last_dz = dz;
  endtask

  initial begin
    exp_t none;
    int   done_seen;
    none = '{hi: '0, lo: '0, dz: 1'b0};

    vecs[0]  = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{OpMult,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{OpMadd,  32'd2,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF5, 1'b0};
    vecs[3]  = '{OpDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{OpDivu,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{OpMultu, 32'd3,         32'd4,         32'd0,         32'd12,        1'b1};
    vecs[7]  = '{OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[8]  = '{OpMaddu, 32'hFFFF_FFFF, 32'd2,         32'd4,         32'h0000_000C, 1'b0};
    vecs[9]  = '{OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{OpDiv,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};

    bus.i_start = 1'b0;
    bus.i_op    = '0;
    bus.i_opr1  = '0;
    bus.i_opr2  = '0;
    bus.i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(bus.o_hi), 64'd0);
    check("rst_lo", 64'(bus.o_lo), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_div_zero", 64'(bus.o_div_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors run back to back: each start lands in the cycle o_done is high.
    for (int i = 0; i < 12; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // Random vectors against a behavioural model.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic [63:0]  p;
      int           sa, sbv;
      a = $urandom;
      case (i % 3)
        0: begin
          b = $urandom;
          p = 64'(a) * 64'(b);
          run(OpMultu, a, b, p[63:32], p[31:0], last_dz);
        end
        1: begin
          b = $urandom_range(1, 65535);
          run(OpDivu, a, b, a % b, a / b, 1'b0);
        end
        default: begin
          sa  = int'(a);
          sbv = int'($urandom_range(2, 500));
          if (i[0]) sbv = -sbv;
          run(OpDiv, a, W'(sbv), W'(sa % sbv), W'(sa / sbv), 1'b0);
        end
      endcase
    end

    // MTHI while idle: immediate, no done, LO untouched.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = OpMthi;
    bus.i_opr1  = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    check("mthi_hi", 64'(bus.o_hi), 64'h1234);
    check("mthi_lo", 64'(bus.o_lo), 64'(last_lo));
    check("mthi_done", 64'(bus.o_done), 64'd0);
    check("mthi_busy", 64'(bus.o_busy), 64'd0);
    last_hi = 32'h0000_1234;

    // MTLO issued while busy must be dropped.
    launch(OpMultu, 32'd6, 32'd7, 1'b1, '{hi: 32'd0, lo: 32'd42, dz: last_dz});
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = OpMtlo;
    bus.i_opr1  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    check("mtlo_busy_lo", 64'(bus.o_lo), 64'(last_lo));
    check("mtlo_busy_busy", 64'(bus.o_busy), 64'd1);
    wait_done();
    last_hi = 32'd0;
    last_lo = 32'd42;

    // Flush at cycle 10 of a DIV: no done, HI/LO unchanged.
    launch(OpDiv, 32'd100, 32'd3, 1'b0, none);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    check("flush_busy", 64'(bus.o_busy), 64'd0);
    check("flush_hi", 64'(bus.o_hi), 64'(last_hi));
    check("flush_lo", 64'(bus.o_lo), 64'(last_lo));
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.o_done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);

    // Flush beats a simultaneous start.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = OpMultu;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    check("flush_start_busy", 64'(bus.o_busy), 64'd0);

    // Leave nonzero state, then reset asynchronously in the middle of CALC.
    run(OpDivu, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
    launch(OpMultu, 32'd5, 32'd5, 1'b0, none);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_hi", 64'(bus.o_hi), 64'd0);
    check("arst_lo", 64'(bus.o_lo), 64'd0);
    check("arst_busy", 64'(bus.o_busy), 64'd0);
    check("arst_done", 64'(bus.o_done), 64'd0);
    check("arst_div_zero", 64'(bus.o_div_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised iterative multiply/divide unit; sits beside the combinational ALU in EX.
- Owns architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU/MADD/MADDU over multiple cycles with a start/busy/done handshake.
- MTHI/MTLO write HI/LO directly; the pipeline stalls on o_busy and reads HI/LO at any time.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  request; accepted only when o_busy=0.
- i_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MTHI, 7 MTLO.
- i_opr1  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- i_opr2  in  WIDTH  multiplier / divisor.
- i_flush  in  1  abort in-flight operation.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse when HI/LO updated by an arithmetic op.
- o_div_zero  out  1  sticky flag for the last divide: divisor was zero.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, i_rst=1): o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_zero=0, state=IDLE, counter=0.
- States:
  - IDLE: accepts requests.
  - CALC: WIDTH iterations.
  - FINISH: sign fix, accumulate, write-back.
- Accept: i_start=1 and state=IDLE at a rising edge (edge 0).
  - i_start while busy is ignored; no queuing.
- MTHI/MTLO: at edge 0, HI or LO ← i_opr1. No busy, no o_done. o_div_zero unchanged.
- Arithmetic ops at edge 0:
  - Latch the absolute values of the operands (signed ops) or the raw operands (unsigned ops).
  - Latch the result signs.
  - Go to CALC with counter=0 and o_busy=1.
- CALC multiply: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit partial product.
- CALC divide: restoring, one quotient bit per cycle.
- CALC duration: edges 1..WIDTH. After counter reaches WIDTH-1 → FINISH.
- FINISH (edge WIDTH+1):
  - Apply the two's-complement sign correction.
  - Write HI/LO.
  - o_done=1 for exactly one cycle; o_busy=0 in the same cycle.
  - Return to IDLE.
- Total latency is WIDTH+1 cycles; a new i_start may be accepted on the cycle o_done is high.
- MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product.
- MADD/MADDU: {HI,LO} = {HI,LO} + product, modulo 2^(2*WIDTH).
  - Uses HI/LO as they stand at FINISH; MTHI/MTLO cannot intervene because busy blocks them.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV with MIN_INT / -1: LO=MIN_INT, HI=0. No trap.
- Divisor zero (DIV or DIVU):
  - Still takes WIDTH+1 cycles.
  - LO = all ones, HI = i_opr1 (as latched).
  - o_div_zero=1.
  - Any other completed divide clears o_div_zero; multiplies leave it unchanged.
- i_flush=1 (synchronous):
  - Forces IDLE at the next edge; o_busy=0.
  - No o_done; HI/LO unchanged.
  - Takes priority over i_start in the same cycle.
  - In FINISH it suppresses the write-back.
- Async reset mid-operation: immediate return to reset values.
- o_hi/o_lo are driven directly from registers; no combinational path from inputs.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) → busy for 33 cycles; o_done pulse at edge 33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MADD 2 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF5.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no o_div_zero.
- DIVU 100 / 0 → after 33 cycles LO=0xFFFFFFFF, HI=100, o_div_zero=1. Next DIVU 100/7 → LO=14, HI=2, o_div_zero=0.
- MTHI 0x1234 while idle → o_hi=0x1234 next cycle, no o_done. MTLO issued during busy → ignored, LO keeps its prior value.
- Assert i_flush at cycle 10 of a DIV → o_busy drops at the next edge, no o_done, HI/LO unchanged. Async i_rst during CALC → all outputs 0 immediately.
